// File: rtl/jtag_uart_tx_master.sv
// ============================================================================
// Module  : jtag_uart_tx_master
// Purpose : Avalon-MM master draining a byte FIFO into a JTAG UART data port,
//           polling WSPACE before every write burst. Optional LF->CRLF
//           expansion when JTAG_TX_CRLF_EN is defined.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module jtag_uart_tx_master #(
  parameter int DEPTH    = 16,
  parameter int POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] c_gap_last = GW'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POLL    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_BACKOFF = 3'd4
  } state_t;

  state_t        r_state, w_state_next;
  logic [15:0]   r_credit, w_credit_next, w_credit_dec;
  logic [GW-1:0] r_gap, w_gap_next;
  logic [CW-1:0] r_count, w_count_next, w_remain, w_push_n;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
  logic [7:0]    r_mem [DEPTH];
  logic          w_push, w_pop;
  logic [7:0]    w_entry0, w_head_next;
  logic          r_avm_read, r_avm_write, r_avm_address;
  logic [31:0]   r_avm_writedata;
  logic          w_unused_rdata;

`ifdef JTAG_TX_CRLF_EN
  localparam logic [CW-1:0] c_depth_m2 = CW'(DEPTH - 2);
  logic w_lf;
  assign w_lf     = (in_data == 8'h0A);
  assign in_ready = reset_n && (r_count <= c_depth_m2);
  assign w_entry0 = w_lf ? 8'h0D : in_data;
  assign w_push_n = w_push ? (w_lf ? CW'(2) : CW'(1)) : '0;
`else
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  assign in_ready = reset_n && (r_count < c_depth);
  assign w_entry0 = in_data;
  assign w_push_n = CW'(w_push);
`endif

  assign w_push        = in_valid && in_ready;
  assign w_pop         = (r_state == S_WRITE);
  assign w_remain      = r_count - CW'(w_pop);
  assign w_count_next  = w_remain + w_push_n;
  assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
  // Head of the FIFO as seen next cycle; forwards the incoming entry when it lands in an empty FIFO.
  assign w_head_next   = (w_remain == '0) ? w_entry0 : r_mem[w_rd_ptr_next];
  assign w_credit_dec  = (r_credit != 16'd0) ? (r_credit - 16'd1) : 16'd0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry0;
`ifdef JTAG_TX_CRLF_EN
      if (w_lf) r_mem[r_wr_ptr + AW'(1)] <= in_data;
`endif
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_gap_next    = r_gap;
    case (r_state)
      S_IDLE:    if (r_count != '0) w_state_next = S_POLL;
      S_POLL:    w_state_next = S_CAPTURE;
      S_CAPTURE: begin
        w_credit_next = avm_readdata[31:16];
        w_gap_next    = '0;
        w_state_next  = (avm_readdata[31:16] == 16'd0) ? S_BACKOFF : S_WRITE;
      end
      S_WRITE: begin
        // Leftover credit is dropped so every burst starts from a fresh poll.
        if ((w_credit_dec == 16'd0) || (w_count_next == '0)) begin
          w_state_next  = S_IDLE;
          w_credit_next = 16'd0;
        end else begin
          w_credit_next = w_credit_dec;
        end
      end
      S_BACKOFF: begin
        if (r_gap == c_gap_last) w_state_next = S_IDLE;
        else                     w_gap_next   = r_gap + GW'(1);
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_credit        <= '0;
      r_gap           <= '0;
      r_count         <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_address   <= 1'b0;
      r_avm_writedata <= '0;
    end else begin
      r_state       <= w_state_next;
      r_credit      <= w_credit_next;
      r_gap         <= w_gap_next;
      r_count       <= w_count_next;
      r_wr_ptr      <= r_wr_ptr + w_push_n[AW-1:0];
      r_rd_ptr      <= w_rd_ptr_next;
      // Strobes are registered from the next state so they line up with it.
      r_avm_read    <= (w_state_next == S_POLL);
      r_avm_address <= (w_state_next == S_POLL);
      r_avm_write   <= (w_state_next == S_WRITE);
      if (w_state_next == S_WRITE) r_avm_writedata <= {24'h0, w_head_next};
    end
  end

  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign avm_address   = r_avm_address;
  assign avm_writedata = r_avm_writedata;
  assign busy          = reset_n && ((r_count != '0) || (r_state != S_IDLE));

  assign w_unused_rdata = ^avm_readdata[15:0];

endmodule

`default_nettype wire
